// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - Sequencer request/response and ALU arbitration signal bundle
interface alu_seq_if;
  logic        req;
  logic [1:0]  cmd;
  logic [31:0] src_0;
  logic [31:0] src_1;
  logic        abort;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;
  logic        dz;
  logic [31:0] ex_in_0;
  logic [31:0] ex_in_1;
  logic [3:0]  ex_op;
  logic [31:0] alu_in_0;
  logic [31:0] alu_in_1;
  logic [3:0]  alu_op;
  logic [31:0] alu_out;

  modport master (
    output req, cmd, src_0, src_1, abort, ex_in_0, ex_in_1, ex_op, alu_out,
    input  busy, stall, done, result, dz, alu_in_0, alu_in_1, alu_op
  );

  modport slave (
    input  req, cmd, src_0, src_1, abort, ex_in_0, ex_in_1, ex_op, alu_out,
    output busy, stall, done, result, dz, alu_in_0, alu_in_1, alu_op
  );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - Multi-cycle MULU/DIVU/REMU sequencer that borrows the shared ALU
module alu_seq (
  input logic      clk,
  input logic      reset_,
  alu_seq_if.slave sif
);
  localparam int         WORD_DATA_W = 32;
  localparam int         ALU_OP_W    = 4;
  localparam logic [ALU_OP_W-1:0] ALU_OP_ADDU = 4'h2;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUBU = 4'h4;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t                 state_q, state_d;
  logic [5:0]             cnt_q, cnt_d;
  logic [WORD_DATA_W-1:0] acc_q, acc_d;
  logic [WORD_DATA_W-1:0] mcand_q, mcand_d;
  logic [WORD_DATA_W-1:0] mplier_q, mplier_d;
  logic [WORD_DATA_W-1:0] rem_q, rem_d;
  logic [WORD_DATA_W-1:0] dvd_q, dvd_d;
  logic [WORD_DATA_W-1:0] dvs_q, dvs_d;
  logic [WORD_DATA_W-1:0] result_q, result_d;
  logic                   dz_q, dz_d;
  logic                   is_rem_q, is_rem_d;

  logic [WORD_DATA_W:0]   sh;
  logic                   ge;
  logic                   busy;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      dz_q     <= 1'b0;
      is_rem_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      dz_q     <= dz_d;
      is_rem_q <= is_rem_d;
    end
  end

  // Restoring-division step: the 33rd bit keeps the compare honest when the
  // shifted remainder overflows 32 bits; the ALU's wrapped difference is still right.
  assign sh = {rem_q, dvd_q[WORD_DATA_W-1]};
  assign ge = sh[WORD_DATA_W] | (sh[WORD_DATA_W-1:0] >= dvs_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    dz_d     = dz_q;
    is_rem_d = is_rem_q;
    case (state_q)
      IDLE: begin
        if (sif.req && !sif.abort) begin
          cnt_d    = '0;
          is_rem_d = (sif.cmd == 2'd2);
          if (sif.cmd == 2'd1 || sif.cmd == 2'd2) begin
            rem_d = '0;
            dvd_d = sif.src_0;
            dvs_d = sif.src_1;
            if (sif.src_1 == '0) begin
              state_d  = DONE;
              result_d = (sif.cmd == 2'd2) ? sif.src_0 : '1;
              dz_d     = 1'b1;
            end else begin
              state_d = DIV;
            end
          end else begin
            acc_d    = '0;
            mcand_d  = sif.src_0;
            mplier_d = sif.src_1;
            state_d  = MUL;
          end
        end
      end
      MUL: begin
        if (mplier_q[0]) acc_d = sif.alu_out;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 6'd1;
        if (sif.abort) begin
          state_d = IDLE;
        end else if (cnt_q == 6'd31) begin
          state_d  = DONE;
          result_d = acc_d;
          dz_d     = 1'b0;
        end
      end
      DIV: begin
        rem_d = ge ? sif.alu_out : sh[WORD_DATA_W-1:0];
        dvd_d = {dvd_q[WORD_DATA_W-2:0], ge};
        cnt_d = cnt_q + 6'd1;
        if (sif.abort) begin
          state_d = IDLE;
        end else if (cnt_q == 6'd31) begin
          state_d  = DONE;
          result_d = is_rem_q ? rem_d : dvd_d;
          dz_d     = 1'b0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q == MUL) || (state_q == DIV);
    sif.busy     = busy;
    sif.stall    = busy;
    sif.done     = (state_q == DONE);
    sif.result   = result_q;
    sif.dz       = dz_q;
    sif.alu_in_0 = sif.ex_in_0;
    sif.alu_in_1 = sif.ex_in_1;
    sif.alu_op   = sif.ex_op;
    case (state_q)
      MUL: begin
        sif.alu_in_0 = acc_q;
        sif.alu_in_1 = mcand_q;
        sif.alu_op   = ALU_OP_ADDU;
      end
      DIV: begin
        sif.alu_in_0 = sh[WORD_DATA_W-1:0];
        sif.alu_in_1 = dvs_q;
        sif.alu_op   = ALU_OP_SUBU;
      end
      default: ;
    endcase
  end
endmodule
